// File: rtl/gate_exerciser_if.sv
// Harness-side bundle for the gate exerciser: run control, cell drive/observe
// and run results. The exerciser uses the slave modport, the harness the master.
interface gate_exerciser_if;
  logic       start;
  logic       abort;
  logic       dut_a;
  logic       dut_b;
  logic       dut_y;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic [3:0] fail_vec;

  modport master (
    output start, abort, dut_y,
    input  dut_a, dut_b, busy, done, pass, err_count, fail_vec
  );

  modport slave (
    input  start, abort, dut_y,
    output dut_a, dut_b, busy, done, pass, err_count, fail_vec
  );
endinterface

// File: rtl/gate_exerciser.sv
// Two-input cell exerciser: walks {A,B} through 00,01,10,11 for LOOPS passes,
// holds each vector SETTLE_CYCLES cycles, samples Y and tallies mismatches
// against TRUTH (bit index = {A,B}).
//
// state  | meaning
// IDLE   | waiting for start; cell inputs parked at 0
// APPLY  | current vector driven, settle counter running
// SAMPLE | one cycle; Y compared against TRUTH[v], next vector chosen
// DONE   | results held, cell inputs parked at 0; start re-runs
module gate_exerciser #(
  parameter logic [3:0] TRUTH         = 4'b0001,
  parameter int         SETTLE_CYCLES = 2,
  parameter int         LOOPS         = 4
) (
  input logic            clk,
  input logic            reset,
  gate_exerciser_if.slave bus
);

  localparam int SW = $clog2(SETTLE_CYCLES) + 1;
  localparam int LW = $clog2(LOOPS) + 1;
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [LW-1:0] L_LAST = LW'(LOOPS - 1);

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    v_q, v_d;
  logic [LW-1:0] l_q, l_d;
  logic [SW-1:0] s_q, s_d;
  logic [1:0]    ab_q, ab_d;
  logic [7:0]    err_q, err_d;
  logic [3:0]    fail_q, fail_d;
  logic          mismatch;

  assign mismatch = (bus.dut_y != TRUTH[v_q]);

  // State and datapath registers; reset parks everything at zero immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      v_q     <= '0;
      l_q     <= '0;
      s_q     <= '0;
      ab_q    <= '0;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      l_q     <= l_d;
      s_q     <= s_d;
      ab_q    <= ab_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  // Next-state and next-datapath logic; abort wins over everything else and
  // keeps the partial results.
  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    l_d     = l_q;
    s_d     = s_q;
    ab_d    = ab_q;
    err_d   = err_q;
    fail_d  = fail_q;
    if (bus.abort) begin
      state_d = IDLE;
      ab_d    = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_d = APPLY;
            v_d     = '0;
            l_d     = '0;
            s_d     = '0;
            ab_d    = '0;
            err_d   = '0;
            fail_d  = '0;
          end
        end
        APPLY: begin
          if (s_q == S_LAST) begin
            state_d = SAMPLE;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
        SAMPLE: begin
          if (mismatch) begin
            if (err_q != 8'hFF) begin
              err_d = err_q + 8'd1;
            end
            fail_d = fail_q | (4'b0001 << v_q);
          end
          s_d = '0;
          if (v_q != 2'd3) begin
            v_d     = v_q + 2'd1;
            ab_d    = v_q + 2'd1;
            state_d = APPLY;
          end else if (l_q != L_LAST) begin
            v_d     = '0;
            ab_d    = '0;
            l_d     = l_q + LW'(1);
            state_d = APPLY;
          end else begin
            ab_d    = '0;
            state_d = DONE;
          end
        end
        default: begin
          state_d = IDLE;
          ab_d    = '0;
        end
      endcase
    end
  end

  // Status outputs decode directly from registered state.
  assign bus.dut_a     = ab_q[1];
  assign bus.dut_b     = ab_q[0];
  assign bus.busy      = (state_q == APPLY) || (state_q == SAMPLE);
  assign bus.done      = (state_q == DONE);
  assign bus.pass      = (state_q == DONE) && (err_q == 8'd0);
  assign bus.err_count = err_q;
  assign bus.fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// Bench for gate_exerciser: three instances (LOOPS = 1, 4, 100) each beside a
// behavioural cell model (ideal NOR, Y stuck-at-0, Y stuck-at-1).
module tb_gate_exerciser;

  localparam int SETTLE = 2;

  typedef struct {
    int         busy_len;
    logic [7:0] err;
    logic [3:0] fv;
    logic       pass;
  } exp_t;

  logic clk;
  logic reset;
  logic [2:0] start_r;
  logic [2:0] abort_r;
  int   mode_r [3];
  int   loops_of [3];

  logic [2:0] busy_w, done_w, pass_w;
  logic [1:0] ab_w   [3];
  logic [7:0] err_w  [3];
  logic [3:0] fail_w [3];

  int checks;
  int errors;
  int cur;
  int busy_cnt;
  logic [2:0] busy_prev, done_prev;

  logic [1:0] vec_q [$];
  exp_t       res_q [$];

  gate_exerciser_if if0 ();
  gate_exerciser_if if1 ();
  gate_exerciser_if if2 ();

  gate_exerciser #(.TRUTH(4'b0001), .SETTLE_CYCLES(SETTLE), .LOOPS(1))
    u_dut0 (.clk(clk), .reset(reset), .bus(if0));
  gate_exerciser #(.TRUTH(4'b0001), .SETTLE_CYCLES(SETTLE), .LOOPS(4))
    u_dut1 (.clk(clk), .reset(reset), .bus(if1));
  gate_exerciser #(.TRUTH(4'b0001), .SETTLE_CYCLES(SETTLE), .LOOPS(100))
    u_dut2 (.clk(clk), .reset(reset), .bus(if2));

  // mode 0: ideal NOR, 1: Y stuck-at-0, 2: Y stuck-at-1
  function automatic logic cell_y(input int mode, input logic a, input logic b);
    case (mode)
      1:       return 1'b0;
      2:       return 1'b1;
      default: return ~(a | b);
    endcase
  endfunction

  function automatic logic mism(input int mode, input int v);
    logic a, b, nor_ref;
    a = (v >= 2);
    b = (v % 2) == 1;
    nor_ref = (v == 0);
    return cell_y(mode, a, b) != nor_ref;
  endfunction

  assign if0.start = start_r[0];
  assign if1.start = start_r[1];
  assign if2.start = start_r[2];
  assign if0.abort = abort_r[0];
  assign if1.abort = abort_r[1];
  assign if2.abort = abort_r[2];
  assign if0.dut_y = cell_y(mode_r[0], if0.dut_a, if0.dut_b);
  assign if1.dut_y = cell_y(mode_r[1], if1.dut_a, if1.dut_b);
  assign if2.dut_y = cell_y(mode_r[2], if2.dut_a, if2.dut_b);

  assign busy_w = {if2.busy, if1.busy, if0.busy};
  assign done_w = {if2.done, if1.done, if0.done};
  assign pass_w = {if2.pass, if1.pass, if0.pass};
  assign ab_w[0] = {if0.dut_a, if0.dut_b};
  assign ab_w[1] = {if1.dut_a, if1.dut_b};
  assign ab_w[2] = {if2.dut_a, if2.dut_b};
  assign err_w[0] = if0.err_count;
  assign err_w[1] = if1.err_count;
  assign err_w[2] = if2.err_count;
  assign fail_w[0] = if0.fail_vec;
  assign fail_w[1] = if1.fail_vec;
  assign fail_w[2] = if2.fail_vec;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard pop side: vectors checked every busy cycle, results on done rise.
  always @(negedge clk) begin
    logic [1:0] ev;
    exp_t e;
    if (busy_w[cur]) begin
      if (!busy_prev[cur]) busy_cnt = 1;
      else busy_cnt = busy_cnt + 1;
      if (vec_q.size() > 0) begin
        ev = vec_q.pop_front();
        chk("vector", 32'(ab_w[cur]), 32'(ev));
      end else begin
        chk("vector_overrun", 32'(busy_w[cur]), 32'd0);
      end
    end
    if (done_w[cur] && !done_prev[cur]) begin
      if (res_q.size() > 0) begin
        e = res_q.pop_front();
        chk("busy_len", 32'(busy_cnt), 32'(e.busy_len));
        chk("err_count", 32'(err_w[cur]), 32'(e.err));
        chk("fail_vec", 32'(fail_w[cur]), 32'(e.fv));
        chk("pass", 32'(pass_w[cur]), 32'(e.pass));
        chk("ab_in_done", 32'(ab_w[cur]), 32'd0);
      end else begin
        chk("unexpected_done", 32'(done_w[cur]), 32'd0);
      end
    end
    busy_prev = busy_w;
    done_prev = done_w;
  end

  // Scoreboard push side: the full vector stream and the final result.
  task automatic push_run(input int idx, input int mode, input bit with_result);
    int cnt;
    int tot;
    exp_t e;
    cnt = 0;
    e.fv = '0;
    for (int l = 0; l < loops_of[idx]; l++)
      for (int v = 0; v < 4; v++)
        for (int r = 0; r <= SETTLE; r++)
          vec_q.push_back(2'(v));
    for (int v = 0; v < 4; v++)
      if (mism(mode, v)) begin
        cnt++;
        e.fv[v] = 1'b1;
      end
    tot = cnt * loops_of[idx];
    e.err = (tot > 255) ? 8'd255 : 8'(tot);
    e.pass = (tot == 0);
    e.busy_len = loops_of[idx] * 4 * (SETTLE + 1);
    if (with_result) res_q.push_back(e);
  endtask

  task automatic pulse_start(input int idx);
    @(posedge clk);
    #1 start_r[idx] = 1'b1;
    @(posedge clk);
    #1 start_r[idx] = 1'b0;
  endtask

  task automatic wait_done(input int idx, input int budget);
    int n;
    n = 0;
    while (!done_w[idx] && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("done_reached", 32'(done_w[idx]), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(res_q.size() + vec_q.size()), 32'd0);
    vec_q.delete();
    res_q.delete();
  endtask

  task automatic run_full(input int idx, input int mode);
    cur = idx;
    mode_r[idx] = mode;
    push_run(idx, mode, 1'b1);
    pulse_start(idx);
    wait_done(idx, 2000);
  endtask

  initial begin
    int pcnt;
    logic [3:0] pfv;
    checks = 0;
    errors = 0;
    cur = 0;
    busy_cnt = 0;
    busy_prev = '0;
    done_prev = '0;
    loops_of[0] = 1;
    loops_of[1] = 4;
    loops_of[2] = 100;
    for (int i = 0; i < 3; i++) mode_r[i] = 0;
    start_r = '0;
    abort_r = '0;
    reset = 1'b1;

    // Reset values on every instance
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_ab", 32'(ab_w[i]), 32'd0);
      chk("rst_flags", 32'({busy_w[i], done_w[i], pass_w[i]}), 32'd0);
      chk("rst_err", 32'(err_w[i]), 32'd0);
      chk("rst_fail", 32'(fail_w[i]), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    // Ideal NOR, single loop
    run_full(0, 0);

    // Start pulsed again mid-run is ignored: same length and results
    cur = 0;
    mode_r[0] = 0;
    push_run(0, 0, 1'b1);
    pulse_start(0);
    repeat (5) @(posedge clk);
    #1 start_r[0] = 1'b1;
    @(posedge clk);
    #1 start_r[0] = 1'b0;
    wait_done(0, 200);

    // Stuck-at-0, four loops
    run_full(1, 1);

    // Stuck-at-1, hundred loops: saturation
    run_full(2, 2);

    // Start while busy, then abort ending busy cycle 20
    cur = 1;
    mode_r[1] = 1;
    push_run(1, 1, 1'b0);
    pulse_start(1);
    repeat (7) @(posedge clk);
    #1 start_r[1] = 1'b1;
    @(posedge clk);
    #1 start_r[1] = 1'b0;
    repeat (11) @(posedge clk);
    #1 abort_r[1] = 1'b1;
    @(posedge clk);
    #1 abort_r[1] = 1'b0;
    pcnt = 0;
    pfv = '0;
    for (int c = 1; c <= 20; c++)
      if (c % (SETTLE + 1) == 0 && mism(1, (c / (SETTLE + 1) - 1) % 4)) begin
        pcnt++;
        pfv[(c / (SETTLE + 1) - 1) % 4] = 1'b1;
      end
    chk("abort_busy_cycles", 32'(busy_cnt), 32'd20);
    chk("abort_busy", 32'(busy_w[1]), 32'd0);
    chk("abort_done", 32'(done_w[1]), 32'd0);
    chk("abort_pass", 32'(pass_w[1]), 32'd0);
    chk("abort_ab", 32'(ab_w[1]), 32'd0);
    chk("abort_err_partial", 32'(err_w[1]), 32'(pcnt));
    chk("abort_fail_partial", 32'(fail_w[1]), 32'(pfv));
    vec_q.delete();
    repeat (10) @(posedge clk);
    #1;
    chk("abort_stays_idle", 32'({busy_w[1], done_w[1]}), 32'd0);

    // Async reset between edges during APPLY
    cur = 0;
    mode_r[0] = 0;
    push_run(0, 0, 1'b0);
    pulse_start(0);
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_busy", 32'(busy_w[0]), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_ab", 32'(ab_w[0]), 32'd0);
    chk("async_rst_flags", 32'({busy_w[0], done_w[0], pass_w[0]}), 32'd0);
    chk("async_rst_err", 32'({err_w[0], fail_w[0]}), 32'd0);
    #1 reset = 1'b0;
    vec_q.delete();
    repeat (5) @(posedge clk);
    #1;
    chk("post_reset_idle", 32'(busy_w[0]), 32'd0);
    run_full(0, 0);

    // Re-start from DONE: stuck-at-0 run, then ideal run clears on start edge
    run_full(0, 1);
    cur = 0;
    mode_r[0] = 0;
    push_run(0, 0, 1'b1);
    pulse_start(0);
    chk("restart_err_clear", 32'(err_w[0]), 32'd0);
    chk("restart_fail_clear", 32'(fail_w[0]), 32'd0);
    chk("restart_done_low", 32'(done_w[0]), 32'd0);
    wait_done(0, 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
